fifo_word_unpacker: RTL and testbench

//  Read-side companion of the parallel-read FIFO. It pops one wide entry (PAR words) per read and

---
 rtl/fifo_word_unpacker.sv | 127 ++++++++++++
 tb/tb_fifo_word_unpacker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_unpacker.sv
// Pops one PAR-word entry from a wide-read FIFO and replays it as a single-word
// valid/ready stream, one DATA_WIDTH word per accepted beat.
module fifo_word_unpacker #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PAR        = 4,
    parameter bit          LSB_FIRST  = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      clear_i,
    input  logic                      fifo_empty_i,
    output logic                      fifo_ren_o,
    input  logic [PAR*DATA_WIDTH-1:0] fifo_dout_i,
    input  logic                      fifo_valid_i,
    output logic [DATA_WIDTH-1:0]     m_data_o,
    output logic                      m_valid_o,
    input  logic                      m_ready_i,
    output logic                      busy_o,
    output logic                      proto_err_o
);

    localparam int unsigned IdxW = $clog2(PAR);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(PAR - 1);

    typedef enum logic [1:0] {StIdle, StWait, StSend} state_e;

    state_e                    state_q, state_d;
    logic [IdxW-1:0]           idx_q, idx_d;
    logic [PAR*DATA_WIDTH-1:0] hold_q, hold_d;
    logic                      m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0]     m_data_q, m_data_d;
    logic                      proto_err_q, proto_err_d;
    logic                      clear_prev_q;
    logic                      ren;
    logic                      fire;
    logic                      last;

    function automatic logic [DATA_WIDTH-1:0] word_sel(input logic [PAR*DATA_WIDTH-1:0] v,
                                                       input logic [IdxW-1:0]           i);
        int unsigned pos;
        pos = LSB_FIRST ? 32'(i) : (PAR - 1 - 32'(i));
        return v[pos*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    assign fire = m_valid_q & m_ready_i;
    assign last = (idx_q == IdxLast);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        proto_err_d = proto_err_q;
        ren         = 1'b0;

        if (clear_i) begin
            state_d     = StIdle;
            idx_d       = '0;
            m_valid_d   = 1'b0;
            proto_err_d = 1'b0;
        end else begin
            // A read discarded by clear may still return the cycle after; tolerate it once.
            if (fifo_valid_i &&
                ((state_q == StSend) || (state_q == StIdle && !clear_prev_q))) begin
                proto_err_d = 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    ren = !fifo_empty_i;
                    if (ren) state_d = StWait;
                end
                StWait: begin
                    if (fifo_valid_i) begin
                        hold_d    = fifo_dout_i;
                        idx_d     = '0;
                        m_valid_d = 1'b1;
                        m_data_d  = word_sel(fifo_dout_i, '0);
                        state_d   = StSend;
                    end
                end
                StSend: begin
                    if (fire) begin
                        if (last) begin
                            idx_d     = '0;
                            m_valid_d = 1'b0;
                            ren       = !fifo_empty_i;
                            state_d   = ren ? StWait : StIdle;
                        end else begin
                            idx_d    = idx_q + 1'b1;
                            m_data_d = word_sel(hold_q, idx_q + 1'b1);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            hold_q       <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            proto_err_q  <= 1'b0;
            clear_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            hold_q       <= hold_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            proto_err_q  <= proto_err_d;
            clear_prev_q <= clear_i;
        end
    end

    // Gate with reset so the combinational request drops as soon as reset asserts.
    assign fifo_ren_o  = ren & rstn_i;
    assign m_valid_o   = m_valid_q;
    assign m_data_o    = m_data_q;
    assign busy_o      = (state_q != StIdle);
    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Directed bench: two unpackers (LSB-first and MSB-first) share one stimulus stream.
module tb_fifo_word_unpacker;

    logic        clk = 1'b0;
    logic        rstn, clear, empty, valid, ready;
    logic [31:0] dout;
    logic        ren_a, mv_a, busy_a, perr_a;
    logic        ren_b, mv_b, busy_b, perr_b;
    logic [7:0]  md_a, md_b;

    always #5 clk = ~clk;

    fifo_word_unpacker #(.DATA_WIDTH(8), .PAR(4), .LSB_FIRST(1'b1)) dut_a (
        .clk_i(clk), .rstn_i(rstn), .clear_i(clear), .fifo_empty_i(empty),
        .fifo_ren_o(ren_a), .fifo_dout_i(dout), .fifo_valid_i(valid),
        .m_data_o(md_a), .m_valid_o(mv_a), .m_ready_i(ready),
        .busy_o(busy_a), .proto_err_o(perr_a)
    );

    fifo_word_unpacker #(.DATA_WIDTH(8), .PAR(4), .LSB_FIRST(1'b0)) dut_b (
        .clk_i(clk), .rstn_i(rstn), .clear_i(clear), .fifo_empty_i(empty),
        .fifo_ren_o(ren_b), .fifo_dout_i(dout), .fifo_valid_i(valid),
        .m_data_o(md_b), .m_valid_o(mv_b), .m_ready_i(ready),
        .busy_o(busy_b), .proto_err_o(perr_b)
    );

    typedef struct {
        logic        empty, valid, ready, clr;
        logic [31:0] dout;
        logic        e_ren, e_mv;
        logic [7:0]  e_md, e_mdb;
        logic        e_busy, e_perr;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    localparam logic [31:0] D1 = 32'h04030201;
    localparam logic [31:0] D2 = 32'h08070605;
    localparam logic [31:0] D3 = 32'h0D0C0B0A;

    task automatic add(input logic em, input logic va, input logic rd, input logic cl,
                       input logic [31:0] d, input logic rn, input logic mv,
                       input logic [7:0] md, input logic [7:0] mdb,
                       input logic bz, input logic pe);
        vec_t v;
        v.empty = em; v.valid = va; v.ready = rd; v.clr = cl; v.dout = d;
        v.e_ren = rn; v.e_mv = mv; v.e_md = md; v.e_mdb = mdb; v.e_busy = bz; v.e_perr = pe;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (step %0d): got %h, expected %h", name, row, act, exp);
    endtask

    task automatic drive(input logic em, input logic va, input logic rd, input logic cl,
                         input logic [31:0] d);
        @(negedge clk);
        empty = em; valid = va; ready = rd; clear = cl; dout = d;
        #1;
    endtask

    initial begin
        logic [7:0] seq_md[4];
        logic [7:0] seq_mdb[4];

        rstn = 1'b0; clear = 1'b0; empty = 1'b1; valid = 1'b0; ready = 1'b0; dout = '0;

        // Idle with empty FIFO
        for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Single entry, sink always ready
        add(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, D1, 0, 0, 0, 0, 1, 0);
        add(1, 0, 1, 0, 0, 0, 1, 8'h01, 8'h04, 1, 0);
        add(1, 0, 1, 0, 0, 0, 1, 8'h02, 8'h03, 1, 0);
        add(1, 0, 1, 0, 0, 0, 1, 8'h03, 8'h02, 1, 0);
        add(1, 0, 1, 0, 0, 0, 1, 8'h04, 8'h01, 1, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // Back-pressure: ready 1,0,0,1,1,0,1
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, D1, 0, 0, 0, 0, 1, 0);
        add(1, 0, 1, 0, 0, 0, 1, 8'h01, 8'h04, 1, 0);
        add(1, 0, 0, 0, 0, 0, 1, 8'h02, 8'h03, 1, 0);
        add(1, 0, 0, 0, 0, 0, 1, 8'h02, 8'h03, 1, 0);
        add(1, 0, 1, 0, 0, 0, 1, 8'h02, 8'h03, 1, 0);
        add(1, 0, 1, 0, 0, 0, 1, 8'h03, 8'h02, 1, 0);
        add(1, 0, 0, 0, 0, 0, 1, 8'h04, 8'h01, 1, 0);
        add(1, 0, 1, 0, 0, 0, 1, 8'h04, 8'h01, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Two back-to-back entries: re-read on the last beat, one bubble
        add(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, D1, 0, 0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1, 8'h01, 8'h04, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1, 8'h02, 8'h03, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1, 8'h03, 8'h02, 1, 0);
        add(0, 0, 1, 0, 0, 1, 1, 8'h04, 8'h01, 1, 0);
        add(1, 1, 1, 0, D2, 0, 0, 0, 0, 1, 0);
        add(1, 0, 1, 0, 0, 0, 1, 8'h05, 8'h08, 1, 0);
        add(1, 0, 1, 0, 0, 0, 1, 8'h06, 8'h07, 1, 0);
        add(1, 0, 1, 0, 0, 0, 1, 8'h07, 8'h06, 1, 0);
        add(1, 0, 1, 0, 0, 0, 1, 8'h08, 8'h05, 1, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // Clear after beat 02, then a fresh entry starts from word 0
        add(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, D1, 0, 0, 0, 0, 1, 0);
        add(1, 0, 1, 0, 0, 0, 1, 8'h01, 8'h04, 1, 0);
        add(1, 0, 1, 0, 0, 0, 1, 8'h02, 8'h03, 1, 0);
        add(1, 0, 0, 1, 0, 0, 1, 8'h03, 8'h02, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, D3, 0, 0, 0, 0, 1, 0);
        add(1, 0, 1, 0, 0, 0, 1, 8'h0A, 8'h0D, 1, 0);
        add(1, 0, 1, 0, 0, 0, 1, 8'h0B, 8'h0C, 1, 0);
        add(1, 0, 1, 0, 0, 0, 1, 8'h0C, 8'h0B, 1, 0);
        add(1, 0, 1, 0, 0, 0, 1, 8'h0D, 8'h0A, 1, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // Clear with a read outstanding: late fifo_valid ignored, no proto_err
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        add(1, 1, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, D2, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 1, 8'h05, 8'h08, 1, 0);
        add(1, 0, 0, 1, 0, 0, 1, 8'h05, 8'h08, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset m_valid", -1, mv_a, 1'b0);
        chk("reset m_data", -1, md_a, 8'h00);
        chk("reset ren", -1, ren_a, 1'b0);
        chk("reset busy", -1, busy_a, 1'b0);
        chk("reset proto_err", -1, perr_a, 1'b0);
        @(negedge clk);
        rstn = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].empty, vecs[i].valid, vecs[i].ready, vecs[i].clr, vecs[i].dout);
            chk("fifo_ren", i, ren_a, vecs[i].e_ren);
            chk("m_valid", i, mv_a, vecs[i].e_mv);
            chk("busy", i, busy_a, vecs[i].e_busy);
            chk("proto_err", i, perr_a, vecs[i].e_perr);
            if (vecs[i].e_mv) begin
                chk("m_data lsb", i, md_a, vecs[i].e_md);
                chk("m_data msb", i, md_b, vecs[i].e_mdb);
            end
        end

        // fifo_valid during SEND sets sticky proto_err without disturbing the held data
        seq_md  = '{8'h01, 8'h01, 8'h01, 8'h02};
        seq_mdb = '{8'h04, 8'h04, 8'h04, 8'h03};
        drive(0, 0, 0, 0, 0);
        chk("seq ren", 100, ren_a, 1'b1);
        drive(1, 1, 0, 0, D1);
        drive(1, 0, 0, 0, 0);
        chk("seq m_valid", 101, mv_a, 1'b1);
        chk("seq m_data lsb", 101, md_a, seq_md[0]);
        chk("seq m_data msb", 101, md_b, seq_mdb[0]);
        drive(1, 1, 0, 0, D2);
        chk("proto_err before", 102, perr_a, 1'b0);
        drive(1, 0, 0, 0, 0);
        chk("proto_err set", 103, perr_a, 1'b1);
        chk("held m_data", 103, md_a, seq_md[1]);
        drive(1, 0, 1, 0, 0);
        chk("proto_err sticky", 104, perr_a, 1'b1);
        chk("held m_data 2", 104, md_a, seq_md[2]);
        drive(1, 0, 0, 0, 0);
        chk("next m_data lsb", 105, md_a, seq_md[3]);
        chk("next m_data msb", 105, md_b, seq_mdb[3]);
        chk("proto_err b", 105, perr_b, 1'b1);

        // Asynchronous reset mid-SEND
        rstn = 1'b0;
        #1;
        chk("midrst m_valid", 106, mv_a, 1'b0);
        chk("midrst m_data a", 106, md_a, 8'h00);
        chk("midrst m_data b", 106, md_b, 8'h00);
        chk("midrst busy", 106, busy_a, 1'b0);
        chk("midrst proto_err", 106, perr_a, 1'b0);
        chk("midrst ren", 106, ren_a, 1'b0);
        @(negedge clk);
        rstn = 1'b1;

        // Stray fifo_valid in IDLE flags an error; clear drops it
        drive(1, 1, 0, 0, D1);
        drive(1, 0, 0, 0, 0);
        chk("idle proto_err", 107, perr_a, 1'b1);
        chk("idle busy", 107, busy_a, 1'b0);
        chk("idle m_valid", 107, mv_a, 1'b0);
        drive(1, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0);
        chk("clear proto_err", 108, perr_a, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
